// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, sticky error flag and optional FWFT read mode.
module fifo_param #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  error_q, error_d;
  logic                  wr_ok, rd_ok;

  // Status flags decoded from the registered count and live thresholds.
  always_comb begin
    full         = (count_q == DEPTH_CNT);
    empty        = (count_q == '0);
    almost_full  = !full && (count_q >= af_thresh);
    almost_empty = !empty && (count_q <= ae_thresh);
  end

  // Accept logic, pointer/count advance and sticky error detection.
  always_comb begin
    rd_ok    = read_enable && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
    wr_ok    = write_enable && (!full || rd_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
    error_d = error_q | (write_enable && full && !rd_ok) | (read_enable && empty);
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; forced to zero while empty so reset reads as 0.
      assign data_out = empty ? '0 : mem[rd_ptr_q];
      assign valid    = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  valid_q;

      // Registered read port: popped word appears one cycle after the pop.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_ok;
          if (rd_ok) dout_q <= mem[rd_ptr_q];
        end
      end

      assign data_out = dout_q;
      assign valid    = valid_q;
    end
  endgenerate

  assign error  = error_q;
  assign count  = count_q;
  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed testbench for fifo_param: a standard-read instance and an FWFT instance.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] af_th, ae_th;

  logic       we, re;
  logic [9:0] din, dout;
  logic       vld, full, empty, afull, aempty, err;
  logic [3:0] cnt;
  logic [2:0] wp, rp;

  logic       fw_we, fw_re;
  logic [9:0] fw_din, fw_dout;
  logic       fw_vld, fw_full, fw_empty, fw_afull, fw_aempty, fw_err;
  logic [3:0] fw_cnt;
  logic [2:0] fw_wp, fw_rp;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fifo_param #(.DATA_WIDTH(10), .ADDR_WIDTH(3), .FWFT(0)) dut (
    .clk(clk), .reset(reset), .write_enable(we), .read_enable(re), .data_in(din),
    .af_thresh(af_th), .ae_thresh(ae_th), .data_out(dout), .valid(vld), .full(full),
    .empty(empty), .almost_full(afull), .almost_empty(aempty), .error(err), .count(cnt),
    .wr_ptr(wp), .rd_ptr(rp)
  );

  fifo_param #(.DATA_WIDTH(10), .ADDR_WIDTH(3), .FWFT(1)) dut_fw (
    .clk(clk), .reset(reset), .write_enable(fw_we), .read_enable(fw_re), .data_in(fw_din),
    .af_thresh(af_th), .ae_thresh(ae_th), .data_out(fw_dout), .valid(fw_vld),
    .full(fw_full), .empty(fw_empty), .almost_full(fw_afull), .almost_empty(fw_aempty),
    .error(fw_err), .count(fw_cnt), .wr_ptr(fw_wp), .rd_ptr(fw_rp)
  );

  // One clock of stimulus on the standard instance; returns 1 time unit after the edge.
  task automatic cyc(input logic w, input logic r, input logic [9:0] d);
    we = w; re = r; din = d;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic fw_cyc(input logic w, input logic r, input logic [9:0] d);
    fw_we = w; fw_re = r; fw_din = d;
    @(posedge clk); #1;
    fw_we = 1'b0; fw_re = 1'b0;
  endtask

  // Short reset pulse placed between clock edges.
  task automatic do_reset;
    reset = 1'b1; #3; reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", cnt); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b want=0", full); end
    total++; if (afull !== 1'b0) begin bad++; $display("FAIL rst_afull got=%b want=0", afull); end
    total++; if (aempty !== 1'b0) begin bad++; $display("FAIL rst_aempty got=%b want=0", aempty); end
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", vld); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_error got=%b want=0", err); end
    total++; if (dout !== 10'h0) begin bad++; $display("FAIL rst_dout got=%h want=0", dout); end
    total++; if ({wp, rp} !== 6'd0) begin bad++; $display("FAIL rst_ptrs got=%0d/%0d want=0/0", wp, rp); end
    total++; if ({fw_vld, fw_empty, fw_dout} !== {2'b01, 10'h0}) begin
      bad++; $display("FAIL rst_fwft got vld=%b empty=%b dout=%h", fw_vld, fw_empty, fw_dout);
    end
    reset = 1'b0;
    // Mid-stream: set error and valid, hold data, then reset between edges.
    cyc(1'b0, 1'b1, 10'h0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL pre_err got=%b want=1", err); end
    cyc(1'b1, 1'b0, 10'h011);
    cyc(1'b1, 1'b0, 10'h022);
    cyc(1'b1, 1'b0, 10'h033);
    cyc(1'b0, 1'b1, 10'h0);
    total++; if ({vld, dout, cnt} !== {1'b1, 10'h011, 4'd2}) begin
      bad++; $display("FAIL pre_rd got vld=%b dout=%h cnt=%0d want 1/011/2", vld, dout, cnt);
    end
    #2; reset = 1'b1; #1;
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL async_count got=%0d want=0", cnt); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL async_empty got=%b want=1", empty); end
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", vld); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL async_error got=%b want=0", err); end
    total++; if (dout !== 10'h0) begin bad++; $display("FAIL async_dout got=%h want=0", dout); end
    total++; if ({wp, rp} !== 6'd0) begin bad++; $display("FAIL async_ptrs got=%0d/%0d", wp, rp); end
    #1; reset = 1'b0;
  endtask

  task automatic test_fill_drain;
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b0, 10'(k));
      total++; if (cnt !== 4'(k)) begin bad++; $display("FAIL fill_cnt got=%0d want=%0d", cnt, k); end
      total++; if (afull !== (k >= 6 && k < 8)) begin
        bad++; $display("FAIL fill_afull k=%0d got=%b", k, afull);
      end
      total++; if (full !== (k == 8)) begin bad++; $display("FAIL fill_full k=%0d got=%b", k, full); end
      total++; if (aempty !== (k <= 2)) begin
        bad++; $display("FAIL fill_aempty k=%0d got=%b", k, aempty);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 10'h0);
      total++; if ({vld, dout} !== {1'b1, 10'(i)}) begin
        bad++; $display("FAIL drain_data got vld=%b dout=%h want 1/%h", vld, dout, i);
      end
      total++; if (cnt !== 4'(8 - i)) begin bad++; $display("FAIL drain_cnt got=%0d want=%0d", cnt, 8 - i); end
    end
    cyc(1'b0, 1'b0, 10'h0);
    total++; if ({vld, dout, empty} !== {1'b0, 10'h008, 1'b1}) begin
      bad++; $display("FAIL idle_hold got vld=%b dout=%h empty=%b want 0/008/1", vld, dout, empty);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 10'h0B1 + 10'(i));
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 10'h0);
      total++; if (dout !== 10'h0B1 + 10'(i)) begin
        bad++; $display("FAIL wrap_a got=%h want=%h", dout, 10'h0B1 + 10'(i));
      end
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 10'h0C1 + 10'(i));
    total++; if ({wp, rp, cnt} !== {3'd2, 3'd5, 4'd5}) begin
      bad++; $display("FAIL wrap_ptr got wp=%0d rp=%0d cnt=%0d want 2/5/5", wp, rp, cnt);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 10'h0);
      total++; if (dout !== 10'h0C1 + 10'(i)) begin
        bad++; $display("FAIL wrap_b got=%h want=%h", dout, 10'h0C1 + 10'(i));
      end
    end
    total++; if ({rp, empty} !== {3'd2, 1'b1}) begin
      bad++; $display("FAIL wrap_end got rp=%0d empty=%b want 2/1", rp, empty);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 10'h101 + 10'(i));
    cyc(1'b1, 1'b0, 10'h3FF);
    total++; if ({cnt, full, err, wp} !== {4'd8, 1'b1, 1'b1, 3'd2}) begin
      bad++; $display("FAIL ovf got cnt=%0d full=%b err=%b wp=%0d want 8/1/1/2", cnt, full, err, wp);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 10'h0);
      total++; if (dout !== 10'h101 + 10'(i)) begin
        bad++; $display("FAIL ovf_data got=%h want=%h", dout, 10'h101 + 10'(i));
      end
    end
    cyc(1'b0, 1'b0, 10'h0);
    total++; if ({empty, err} !== 2'b11) begin
      bad++; $display("FAIL ovf_sticky got empty=%b err=%b want 1/1", empty, err);
    end
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", err); end
  endtask

  task automatic test_underflow;
    cyc(1'b1, 1'b1, 10'h155);
    total++; if ({err, cnt, vld} !== {1'b1, 4'd1, 1'b0}) begin
      bad++; $display("FAIL udf got err=%b cnt=%0d vld=%b want 1/1/0", err, cnt, vld);
    end
    cyc(1'b0, 1'b1, 10'h0);
    total++; if ({vld, dout, cnt} !== {1'b1, 10'h155, 4'd0}) begin
      bad++; $display("FAIL udf_rd got vld=%b dout=%h cnt=%0d want 1/155/0", vld, dout, cnt);
    end
    do_reset();
  endtask

  task automatic test_full_rw;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 10'h201 + 10'(i));
    cyc(1'b1, 1'b1, 10'h2AA);
    total++; if ({err, cnt, wp, rp} !== {1'b0, 4'd8, 3'd1, 3'd1}) begin
      bad++; $display("FAIL frw got err=%b cnt=%0d wp=%0d rp=%0d want 0/8/1/1", err, cnt, wp, rp);
    end
    total++; if ({vld, dout} !== {1'b1, 10'h201}) begin
      bad++; $display("FAIL frw_rd got vld=%b dout=%h want 1/201", vld, dout);
    end
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, 10'h0);
      total++; if (dout !== 10'h202 + 10'(i)) begin
        bad++; $display("FAIL frw_data got=%h want=%h", dout, 10'h202 + 10'(i));
      end
    end
    cyc(1'b0, 1'b1, 10'h0);
    total++; if ({dout, cnt} !== {10'h2AA, 4'd0}) begin
      bad++; $display("FAIL frw_last got dout=%h cnt=%0d want 2aa/0", dout, cnt);
    end
  endtask

  task automatic test_thresholds;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 10'h0);
    af_th = 4'd3; #1;
    total++; if (afull !== 1'b1) begin bad++; $display("FAIL th_af3 got=%b want=1", afull); end
    af_th = 4'd4; #1;
    total++; if (afull !== 1'b0) begin bad++; $display("FAIL th_af4 got=%b want=0", afull); end
    af_th = 4'd0; #1;
    total++; if (afull !== 1'b1) begin bad++; $display("FAIL th_af0 got=%b want=1", afull); end
    ae_th = 4'd0; #1;
    total++; if (aempty !== 1'b0) begin bad++; $display("FAIL th_ae0 got=%b want=0", aempty); end
    ae_th = 4'd3; #1;
    total++; if (aempty !== 1'b1) begin bad++; $display("FAIL th_ae3 got=%b want=1", aempty); end
    af_th = 4'd6; ae_th = 4'd2; #1;
    total++; if ({afull, aempty} !== 2'b00) begin
      bad++; $display("FAIL th_restore got af=%b ae=%b want 0/0", afull, aempty);
    end
    cyc(1'b0, 1'b0, 10'h0);
    do_reset();
  endtask

  task automatic test_fwft;
    fw_cyc(1'b1, 1'b0, 10'h123);
    total++; if ({fw_vld, fw_dout, fw_cnt} !== {1'b1, 10'h123, 4'd1}) begin
      bad++; $display("FAIL fw_show got vld=%b dout=%h cnt=%0d want 1/123/1", fw_vld, fw_dout, fw_cnt);
    end
    fw_cyc(1'b0, 1'b0, 10'h0);
    total++; if ({fw_vld, fw_dout} !== {1'b1, 10'h123}) begin
      bad++; $display("FAIL fw_hold got vld=%b dout=%h want 1/123", fw_vld, fw_dout);
    end
    fw_cyc(1'b0, 1'b1, 10'h0);
    total++; if ({fw_empty, fw_vld} !== 2'b10) begin
      bad++; $display("FAIL fw_pop got empty=%b vld=%b want 1/0", fw_empty, fw_vld);
    end
    fw_cyc(1'b1, 1'b0, 10'h045);
    fw_cyc(1'b1, 1'b0, 10'h067);
    total++; if ({fw_dout, fw_cnt} !== {10'h045, 4'd2}) begin
      bad++; $display("FAIL fw_head got dout=%h cnt=%0d want 045/2", fw_dout, fw_cnt);
    end
    fw_cyc(1'b0, 1'b1, 10'h0);
    total++; if ({fw_vld, fw_dout} !== {1'b1, 10'h067}) begin
      bad++; $display("FAIL fw_next got vld=%b dout=%h want 1/067", fw_vld, fw_dout);
    end
    fw_cyc(1'b0, 1'b1, 10'h0);
    total++; if ({fw_empty, fw_vld, fw_err} !== 3'b100) begin
      bad++; $display("FAIL fw_end got empty=%b vld=%b err=%b want 1/0/0", fw_empty, fw_vld, fw_err);
    end
  endtask

  initial begin
    we = 1'b0; re = 1'b0; din = '0;
    fw_we = 1'b0; fw_re = 1'b0; fw_din = '0;
    af_th = 4'd6; ae_th = 4'd2;
    #1;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_overflow();
    test_underflow();
    test_full_rw();
    test_thresholds();
    test_fwft();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO. It succeeds the fixed 10-bit/8-entry FIFO in the FIFO subsystem and adds the following:
- configurable width and depth
- runtime-programmable almost-full/almost-empty thresholds
- an occupancy count
- a sticky overflow/underflow error
- a selectable first-word-fall-through (FWFT) read mode

It sits between the producer and consumer stages of the datapath and is the drop-in FIFO for all multi-depth buffering.

Parameters:
DATA_WIDTH, 10, data word width in bits
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries (default 8)
FWFT, 0, 0 = standard registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
write_enable  input  1  push request
read_enable  input  1  pop request
data_in  input  DATA_WIDTH  write data
af_thresh  input  ADDR_WIDTH+1  almost-full threshold (entries)
ae_thresh  input  ADDR_WIDTH+1  almost-empty threshold (entries)
data_out  output  DATA_WIDTH  read data
valid  output  1  data_out holds a popped/head word
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  af_thresh <= count < DEPTH
almost_empty  output  1  0 < count <= ae_thresh
error  output  1  sticky overflow/underflow flag
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
wr_ptr  output  ADDR_WIDTH  write address
rd_ptr  output  ADDR_WIDTH  read address

Behaviour:
- Reset (async, active-high; takes effect immediately, at any time including mid-transfer):
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid=0, error=0
  - full=0, empty=1, almost_full=0, almost_empty=0
  - Memory contents are don't-care.
- Accepted write: write_enable && (!full || accepted read in the same cycle).
  - mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH (natural wrap at 2**ADDR_WIDTH).
- Accepted read: read_enable && !empty. rd_ptr increments modulo DEPTH.
- count: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write. Never exceeds DEPTH and never underflows.
- Overflow: write_enable && full && no accepted read. Write is dropped; pointers and count are unchanged; error <= 1.
- Underflow: read_enable && empty. Read is ignored; error <= 1. A write in the same cycle is still accepted (count 0 -> 1).
- Simultaneous read+write when full: both are accepted; no error; count stays DEPTH.
- error is sticky; only reset clears it.
- Flags are combinational from the count register (same-cycle consistent with count, wr_ptr, rd_ptr).
  - almost_full and full are mutually exclusive; almost_empty and empty are mutually exclusive.
  - Thresholds are sampled every cycle; a threshold change updates the flags combinationally.
  - af_thresh=0 makes almost_full track !full; ae_thresh=0 holds almost_empty at 0.
- FWFT=0 (standard read):
  - On an accepted read in cycle N, data_out <= mem[rd_ptr] and valid <= 1, both visible after edge N.
  - If no accepted read, valid <= 0 and data_out holds its last value.
- FWFT=1 (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally; valid = !empty.
  - read_enable acknowledges (pops) the displayed word.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- Write-to-read ordering is strict FIFO across pointer wrap.

Test Plan:
1. Reset mid-stream: write 3 words, assert reset asynchronously between edges -> count=0, empty=1, valid=0, error=0, data_out=0 immediately, before the next edge.
2. Fill/drain with wrap, DEPTH=8, FWFT=0, af_thresh=6, ae_thresh=2:
   - Write 0x001..0x008 -> almost_full=1 at count 6..7; full=1 at count 8, almost_full=0.
   - Read 8 words -> 0x001..0x008 in order, each one cycle after its read_enable with valid=1.
   - Write/read 5 more words -> pointers wrap 7 -> 0; data order preserved.
3. Overflow: at full, write 0x3FF with no read -> word dropped, count stays 8, error=1. Error stays 1 after draining until reset.
4. Underflow + simultaneous write: empty, read_enable=write_enable=1, data_in=0x155 -> error=1, count=1, next read returns 0x155.
5. Full simultaneous read/write: at count=8, read+write 0x2AA -> no error, count=8, wr_ptr and rd_ptr both advance. 0x2AA is returned after the 7 older words.
6. FWFT=1: write 0x123 into empty FIFO -> next cycle data_out=0x123, valid=1 without read_enable. Pulse read_enable -> empty=1, valid=0.
